scan_mux: RTL and testbench

SCAN_MUX -- requirements
Module: scan_mux

---
 rtl/scan_mux.sv | 134 +++++++++++++
 tb/tb_scan_mux.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// ============================================================================
// Module      : scan_mux
// Description : Registered NCH-to-1 channel mux with manual select and a
//               timed auto-scan mode (dwell counter, hold, wrap pulse).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_mux #(
  parameter int NCH   = 4,
  parameter int W     = 1,
  parameter int DWELL = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic              hold,
  input  logic [NCH*W-1:0]  din,
  output logic [W-1:0]      y,
  output logic [SELW-1:0]   ch,
  output logic              valid,
  output logic              wrap
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t          r_state, w_state;
  logic [W-1:0]    r_y, w_y;
  logic [SELW-1:0] r_ch, w_ch, w_scan_ch;
  logic            r_valid, w_valid;
  logic            r_wrap, w_wrap;
  logic [7:0]      r_cnt, w_cnt;
  logic [W-1:0]    w_sel_data;
  logic            w_sel_ok;

  // Loop-based mux so an out-of-range index simply selects nothing.
  function automatic logic [W-1:0] pick(input logic [SELW-1:0] idx,
                                        input logic [NCH*W-1:0] data);
    logic [W-1:0] res;
    res = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx == SELW'(k)) res = data[k*W +: W];
    end
    return res;
  endfunction

  always_comb begin
    w_sel_ok = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k)) w_sel_ok = 1'b1;
    end
    w_sel_data = pick(sel, din);
  end

  always_comb begin
    w_state   = IDLE;
    w_y       = r_y;
    w_ch      = r_ch;
    w_valid   = 1'b0;
    w_wrap    = 1'b0;
    w_cnt     = r_cnt;
    w_scan_ch = r_ch;

    if (en) w_state = mode ? SCAN : MANUAL;

    case (w_state)
      MANUAL: begin
        w_cnt = '0;
        if (w_sel_ok) begin
          w_y     = w_sel_data;
          w_ch    = sel;
          w_valid = 1'b1;
        end else begin
          w_y = '0;
        end
      end
      SCAN: begin
        w_valid = 1'b1;
        if (r_state != SCAN) begin
          w_scan_ch = '0;
          w_cnt     = '0;
        end else if (!hold) begin
          if (r_cnt == 8'(DWELL - 1)) begin
            w_cnt = '0;
            if (r_ch == SELW'(NCH - 1)) begin
              w_scan_ch = '0;
              w_wrap    = 1'b1;
            end else begin
              w_scan_ch = r_ch + SELW'(1);
            end
          end else begin
            w_cnt = r_cnt + 8'd1;
          end
        end
        w_ch = w_scan_ch;
        w_y  = pick(w_scan_ch, din);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_y     <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_y     <= w_y;
      r_ch    <= w_ch;
      r_valid <= w_valid;
      r_wrap  <= w_wrap;
      r_cnt   <= w_cnt;
    end
  end

  assign y     = r_y;
  assign ch    = r_ch;
  assign valid = r_valid;
  assign wrap  = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_scan_mux.sv
// ============================================================================
// Module      : tb_scan_mux
// Description : Self-checking bench for scan_mux (directed + randomized).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_mux;

  localparam int A_NCH = 4, A_W = 1, A_DWELL = 2;
  localparam int B_NCH = 3, B_W = 2, B_DWELL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, mode_a, hold_a;
  logic [1:0] sel_a;
  logic [3:0] din_a;
  logic       y_a;
  logic [1:0] ch_a;
  logic       valid_a, wrap_a;

  logic       en_b, mode_b, hold_b;
  logic [1:0] sel_b;
  logic [5:0] din_b;
  logic [1:0] y_b;
  logic [1:0] ch_b;
  logic       valid_b, wrap_b;

  int checks = 0;
  int passes = 0;

  // Reference model for DUT A: scan position is a tick count since scan entry.
  int         m_st = 0;
  int         m_t  = 0;
  logic       m_y = 1'b0;
  logic [1:0] m_ch = 2'd0;
  logic       m_valid = 1'b0, m_wrap = 1'b0;

  scan_mux #(.NCH(A_NCH), .W(A_W), .DWELL(A_DWELL)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .sel(sel_a), .hold(hold_a),
    .din(din_a), .y(y_a), .ch(ch_a), .valid(valid_a), .wrap(wrap_a)
  );

  scan_mux #(.NCH(B_NCH), .W(B_W), .DWELL(B_DWELL)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .sel(sel_b), .hold(hold_b),
    .din(din_b), .y(y_b), .ch(ch_b), .valid(valid_b), .wrap(wrap_b)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    if (rst) begin
      m_st = 0; m_t = 0; m_y = 1'b0; m_ch = 2'd0; m_valid = 1'b0; m_wrap = 1'b0;
    end else if (!en_a) begin
      m_st = 0; m_valid = 1'b0; m_wrap = 1'b0;
    end else if (!mode_a) begin
      m_st = 1; m_wrap = 1'b0; m_ch = sel_a; m_y = din_a[sel_a]; m_valid = 1'b1;
    end else begin
      m_wrap = 1'b0;
      if (m_st != 2) m_t = 0;
      else if (!hold_a) begin
        m_t++;
        m_wrap = ((m_t % (A_DWELL * A_NCH)) == 0);
      end
      m_st    = 2;
      m_ch    = 2'((m_t / A_DWELL) % A_NCH);
      m_y     = din_a[m_ch];
      m_valid = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en_a = 0; mode_a = 0; hold_a = 0; sel_a = 0; din_a = 4'hF;
    en_b = 0; mode_b = 0; hold_b = 0; sel_b = 0; din_b = 6'h3F;
    tick(); tick();
    checks++;
    if ({y_a, ch_a, valid_a, wrap_a} !== 5'b0)
      $display("FAIL reset_a: got y=%b ch=%0d valid=%b wrap=%b, want all 0", y_a, ch_a, valid_a, wrap_a);
    else passes++;
    checks++;
    if ({y_b, ch_b, valid_b, wrap_b} !== 6'b0)
      $display("FAIL reset_b: got y=%0d ch=%0d valid=%b wrap=%b, want all 0", y_b, ch_b, valid_b, wrap_b);
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_manual();
    logic exp_y [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    en_a = 1; mode_a = 0; din_a = 4'b0100;
    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s);
      tick();
      checks++;
      if ({y_a, ch_a, valid_a, wrap_a} !== {exp_y[s], 2'(s), 1'b1, 1'b0})
        $display("FAIL manual_sel%0d: got y=%b ch=%0d valid=%b wrap=%b, want y=%b ch=%0d valid=1 wrap=0",
                 s, y_a, ch_a, valid_a, wrap_a, exp_y[s], s);
      else passes++;
    end
  endtask

  task automatic test_scan_wrap();
    int exp_ch [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    logic exp_y [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    en_a = 1; mode_a = 1; hold_a = 0; din_a = 4'b1010;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if ({y_a, ch_a, valid_a, wrap_a} !== {exp_y[i], 2'(exp_ch[i]), 1'b1, (i == 8)})
        $display("FAIL scan_wrap_step%0d: got y=%b ch=%0d valid=%b wrap=%b, want y=%b ch=%0d valid=1 wrap=%b",
                 i, y_a, ch_a, valid_a, wrap_a, exp_y[i], exp_ch[i], (i == 8));
      else passes++;
    end
  endtask

  task automatic test_hold();
    logic e;
    en_a = 0; tick();
    en_a = 1; mode_a = 1; hold_a = 0; din_a = 4'b1010;
    tick();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (ch_a !== 2'd2) $display("FAIL hold_setup: got ch=%0d, want 2", ch_a);
    else passes++;
    hold_a = 1;
    for (int i = 0; i < 5; i++) begin
      din_a[2] = ~din_a[2];
      e = din_a[2];
      tick();
      checks++;
      if ({y_a, ch_a, valid_a, wrap_a} !== {e, 2'd2, 1'b1, 1'b0})
        $display("FAIL hold_cycle%0d: got y=%b ch=%0d valid=%b wrap=%b, want y=%b ch=2 valid=1 wrap=0",
                 i, y_a, ch_a, valid_a, wrap_a, e);
      else passes++;
    end
    hold_a = 0;
    tick();
    checks++;
    if (ch_a !== 2'd2) $display("FAIL hold_release1: got ch=%0d, want 2", ch_a);
    else passes++;
    tick();
    checks++;
    if ({ch_a, y_a} !== {2'd3, din_a[3]})
      $display("FAIL hold_release2: got ch=%0d y=%b, want ch=3 y=%b", ch_a, y_a, din_a[3]);
    else passes++;
  endtask

  task automatic test_out_of_range();
    en_b = 1; mode_b = 0; din_b = {2'd3, 2'd2, 2'd1};
    sel_b = 2'd1; tick();
    checks++;
    if ({y_b, ch_b, valid_b} !== {2'd2, 2'd1, 1'b1})
      $display("FAIL oor_sel1: got y=%0d ch=%0d valid=%b, want y=2 ch=1 valid=1", y_b, ch_b, valid_b);
    else passes++;
    sel_b = 2'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({y_b, ch_b, valid_b, wrap_b} !== {2'd0, 2'd1, 1'b0, 1'b0})
        $display("FAIL oor_sel3_%0d: got y=%0d ch=%0d valid=%b wrap=%b, want y=0 ch=1 valid=0 wrap=0",
                 i, y_b, ch_b, valid_b, wrap_b);
      else passes++;
    end
    sel_b = 2'd2; tick();
    checks++;
    if ({y_b, ch_b, valid_b} !== {2'd3, 2'd2, 1'b1})
      $display("FAIL oor_sel2: got y=%0d ch=%0d valid=%b, want y=3 ch=2 valid=1", y_b, ch_b, valid_b);
    else passes++;
    en_b = 0;
  endtask

  task automatic test_reset_mid_scan();
    en_a = 0; tick();
    en_a = 1; mode_a = 1; hold_a = 0; din_a = 4'b1011;
    tick();
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if ({y_a, ch_a, valid_a} !== {1'b1, 2'd3, 1'b1})
      $display("FAIL rstmid_setup: got y=%b ch=%0d valid=%b, want y=1 ch=3 valid=1", y_a, ch_a, valid_a);
    else passes++;
    rst = 1; tick();
    checks++;
    if ({y_a, ch_a, valid_a, wrap_a} !== 5'b0)
      $display("FAIL rstmid_reset: got y=%b ch=%0d valid=%b wrap=%b, want all 0", y_a, ch_a, valid_a, wrap_a);
    else passes++;
    rst = 0; tick();
    checks++;
    if ({y_a, ch_a, valid_a, wrap_a} !== {1'b1, 2'd0, 1'b1, 1'b0})
      $display("FAIL rstmid_restart: got y=%b ch=%0d valid=%b wrap=%b, want y=1 ch=0 valid=1 wrap=0",
               y_a, ch_a, valid_a, wrap_a);
    else passes++;
    tick(); tick();
    checks++;
    if (ch_a !== 2'd1) $display("FAIL rstmid_advance: got ch=%0d, want 1", ch_a);
    else passes++;
  endtask

  task automatic test_enable_drop_at_wrap();
    en_a = 0; tick();
    en_a = 1; mode_a = 1; hold_a = 0; din_a = 4'b1010;
    tick();
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if ({ch_a, wrap_a} !== {2'd3, 1'b0})
      $display("FAIL endrop_setup: got ch=%0d wrap=%b, want ch=3 wrap=0", ch_a, wrap_a);
    else passes++;
    en_a = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({y_a, ch_a, valid_a, wrap_a} !== {1'b1, 2'd3, 1'b0, 1'b0})
        $display("FAIL endrop_idle%0d: got y=%b ch=%0d valid=%b wrap=%b, want y=1 ch=3 valid=0 wrap=0",
                 i, y_a, ch_a, valid_a, wrap_a);
      else passes++;
    end
  endtask

  task automatic test_random();
    int wraps = 0;
    mode_a = 1;
    for (int i = 0; i < 1500; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      en_a   = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) mode_a = ~mode_a;
      sel_a  = 2'($urandom_range(0, 3));
      hold_a = ($urandom_range(0, 4) == 0);
      din_a  = 4'($urandom_range(0, 15));
      tick();
      if (m_wrap) wraps++;
      checks++;
      if ({y_a, ch_a, valid_a, wrap_a} !== {m_y, m_ch, m_valid, m_wrap})
        $display("FAIL random_cycle%0d: got y=%b ch=%0d valid=%b wrap=%b, want y=%b ch=%0d valid=%b wrap=%b",
                 i, y_a, ch_a, valid_a, wrap_a, m_y, m_ch, m_valid, m_wrap);
      else passes++;
    end
    rst = 0;
    checks++;
    if (wraps == 0) $display("FAIL random_coverage: got %0d model wraps, want at least 1", wraps);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_wrap();
    test_hold();
    test_out_of_range();
    test_reset_mid_scan();
    test_enable_drop_at_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
